vpu_op_issuer: RTL and testbench

VPU_OP_ISSUER -- requirements
Module: vpu_op_issuer

---
 rtl/vpu_issue_pkg.sv | 13 +
 rtl/vpu_wait_timer.sv | 39 +++
 rtl/vpu_op_issuer.sv | 148 ++++++++++++++
 tb/tb_vpu_op_issuer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_issue_pkg.sv
// vpu_issue_pkg: shared FSM state type and encodings for the VPU operation issuer.
package vpu_issue_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } state_e;

endpackage

// File: rtl/vpu_wait_timer.sv
// vpu_wait_timer: clearable saturating cycle counter with a compare against
// the watchdog limit. The compare output is only consumed when the issuer is
// built with VPU_OP_ISSUER_TIMEOUT_EN.
module vpu_wait_timer #(
  parameter int WAIT_CNT_W     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  output logic [WAIT_CNT_W-1:0] cnt,
  output logic                  timeout
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(TIMEOUT_CYCLES);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WAIT_CNT_W-1:0] sat_inc(input logic [WAIT_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Counter register: clear has priority over counting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= sat_inc(cnt);
    end
  end

  // Watchdog compare on the current count value.
  always_comb begin
    timeout = (cnt == TIMEOUT_VAL);
  end

endmodule

// File: rtl/vpu_op_issuer.sv
// vpu_op_issuer: accepts one operation request at a time, pulses start to an
// external execution counter, waits for its done pulse while measuring the
// wait time, then returns the tag and measured cycles on a response handshake.
// Optional macro VPU_OP_ISSUER_TIMEOUT_EN adds a watchdog that forces an error
// response after TIMEOUT_CYCLES wait cycles.
module vpu_op_issuer
  import vpu_issue_pkg::*;
#(
  parameter int MAX_DELAY_LG2  = 4,
  parameter int ID_W           = 4,
  parameter int WAIT_CNT_W     = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [MAX_DELAY_LG2-1:0] req_delay_i,
  input  logic [ID_W-1:0]          req_id_i,
  output logic                     start_o,
  output logic [MAX_DELAY_LG2-1:0] count_o,
  input  logic                     done_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [ID_W-1:0]          rsp_id_o,
  output logic [WAIT_CNT_W-1:0]    rsp_cycles_o,
  output logic                     rsp_err_o,
  output logic                     busy_o
);

  state_e                   state_q;
  state_e                   state_d;
  logic [ID_W-1:0]          id_q;
  logic [MAX_DELAY_LG2-1:0] delay_q;
  logic [WAIT_CNT_W-1:0]    cycles_q;
  logic                     timer_clr;
  logic                     timer_en;
  logic [WAIT_CNT_W-1:0]    wait_cnt;
  logic                     timeout_hit;

  vpu_wait_timer #(
    .WAIT_CNT_W     (WAIT_CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr),
    .en      (timer_en),
    .cnt     (wait_cnt),
    .timeout (timeout_hit)
  );

`ifdef VPU_OP_ISSUER_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_VAL = WAIT_CNT_W'(TIMEOUT_CYCLES);
  logic err_q;
`else
  logic timeout_unused;
  assign timeout_unused = timeout_hit;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control outputs; handshake/status outputs are forced low
  // while reset is asserted so an aborted operation never shows a response.
  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    start_o     = 1'b0;
    rsp_valid_o = 1'b0;
    count_o     = '0;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;
    busy_o      = rst_n && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = ISSUE;
      end
      ISSUE: begin
        start_o   = rst_n;
        count_o   = delay_q;
        timer_clr = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        count_o  = delay_q;
        timer_en = 1'b1;
        if (done_i) begin
          state_d = RESP;
`ifdef VPU_OP_ISSUER_TIMEOUT_EN
        end else if (timeout_hit) begin
          state_d = RESP;
`endif
        end
      end
      RESP: begin
        rsp_valid_o = rst_n;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request capture on acceptance and result capture on leaving WAIT.
  // A zero delay is promoted to one so the execution counter always runs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_q     <= '0;
      delay_q  <= '0;
      cycles_q <= '0;
`ifdef VPU_OP_ISSUER_TIMEOUT_EN
      err_q    <= 1'b0;
`endif
    end else begin
      if (state_q == IDLE && req_valid_i) begin
        id_q    <= req_id_i;
        delay_q <= (req_delay_i == '0) ? MAX_DELAY_LG2'(1) : req_delay_i;
      end
      if (state_q == WAIT) begin
        if (done_i) begin
          cycles_q <= wait_cnt;
`ifdef VPU_OP_ISSUER_TIMEOUT_EN
          err_q    <= 1'b0;
        end else if (timeout_hit) begin
          cycles_q <= TIMEOUT_VAL;
          err_q    <= 1'b1;
`endif
        end
      end
    end
  end

  assign rsp_id_o     = id_q;
  assign rsp_cycles_o = cycles_q;
`ifdef VPU_OP_ISSUER_TIMEOUT_EN
  assign rsp_err_o    = err_q && rst_n;
`else
  assign rsp_err_o    = 1'b0;
`endif

endmodule

// File: tb/tb_vpu_op_issuer.sv
// tb_vpu_op_issuer: randomized self-checking bench for vpu_op_issuer. The
// bench acts as the execution counter and response consumer; expected
// responses come from a cycle-count model of the operation lifecycle.
// Honours VPU_OP_ISSUER_TIMEOUT_EN when defined for the build.
module tb_vpu_op_issuer;

  localparam int DW  = 4;
  localparam int IW  = 4;
  localparam int CW  = 8;
  localparam int TO  = 64;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid_i;
  logic          req_ready_o;
  logic [DW-1:0] req_delay_i;
  logic [IW-1:0] req_id_i;
  logic          start_o;
  logic [DW-1:0] count_o;
  logic          done_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [IW-1:0] rsp_id_o;
  logic [CW-1:0] rsp_cycles_o;
  logic          rsp_err_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;

  vpu_op_issuer #(
    .MAX_DELAY_LG2  (DW),
    .ID_W           (IW),
    .WAIT_CNT_W     (CW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_delay_i  (req_delay_i),
    .req_id_i     (req_id_i),
    .start_o      (start_o),
    .count_o      (count_o),
    .done_i       (done_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_id_o     (rsp_id_o),
    .rsp_cycles_o (rsp_cycles_o),
    .rsp_err_o    (rsp_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  // Reference model: given when done arrives (WAIT cycles before it, -1 for
  // never), how many WAIT cycles elapse before RESP and what is reported.
  function automatic void model_rsp(input int done_at, output int n_wait,
                                    output int cyc, output bit err);
`ifdef VPU_OP_ISSUER_TIMEOUT_EN
    if (done_at >= 0 && done_at <= TO) begin
      n_wait = done_at; err = 1'b0;
    end else begin
      n_wait = TO; err = 1'b1;
    end
    cyc = n_wait;
`else
    n_wait = done_at;
    err    = 1'b0;
    cyc    = (done_at > SAT) ? SAT : done_at;
`endif
  endfunction

  // One complete operation: request, start, wait, response with optional
  // back-pressure. Spurious done pulses may be injected in ISSUE and RESP.
  task automatic run_op(input int delay, input int id, input int done_at,
                        input int hold, input bit spur_issue, input string tag);
    int n_wait, cyc, k, starts, eff;
    bit err;
    model_rsp(done_at, n_wait, cyc, err);
    eff    = (delay == 0) ? 1 : delay;
    starts = 0;
    @(negedge clk);
    checks++;
    if (req_ready_o !== 1'b1) begin
      errors++; $display("FAIL %s idle_ready: got %0b want 1", tag, req_ready_o);
    end
    req_valid_i = 1'b1; req_delay_i = DW'(delay); req_id_i = IW'(id);
    @(posedge clk); @(negedge clk);
    req_valid_i = 1'b0;
    done_i = spur_issue;
    if (start_o === 1'b1) starts++;
    checks++;
    if (count_o !== DW'(eff) || busy_o !== 1'b1 || req_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL %s issue: count=%0d busy=%0b ready=%0b want count=%0d busy=1 ready=0",
               tag, count_o, busy_o, req_ready_o, eff);
    end
    @(posedge clk); @(negedge clk);
    k = 0;
    while (rsp_valid_o !== 1'b1 && k <= 2000) begin
      if (start_o === 1'b1) starts++;
      checks++;
      if (count_o !== DW'(eff)) begin
        errors++; $display("FAIL %s wait_count k=%0d: got %0d want %0d", tag, k, count_o, eff);
      end
      done_i = (k == done_at);
      @(posedge clk); @(negedge clk);
      k++;
    end
    done_i = 1'b0;
    checks++;
    if (k != n_wait + 1) begin
      errors++; $display("FAIL %s wait_len: got %0d want %0d", tag, k, n_wait + 1);
    end
    checks++;
    if (starts != 1) begin
      errors++; $display("FAIL %s start_pulses: got %0d want 1", tag, starts);
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (rsp_valid_o !== 1'b1 || rsp_id_o !== IW'(id) || rsp_cycles_o !== CW'(cyc) ||
          rsp_err_o !== err || req_ready_o !== 1'b0 || count_o !== '0) begin
        errors++;
        $display("FAIL %s resp h=%0d: valid=%0b id=%0d cyc=%0d err=%0b ready=%0b count=%0d want 1/%0d/%0d/%0b/0/0",
                 tag, h, rsp_valid_o, rsp_id_o, rsp_cycles_o, rsp_err_o, req_ready_o, count_o,
                 id, cyc, err);
      end
      if (h < hold) begin
        req_valid_i = 1'b1; req_id_i = ~IW'(id); req_delay_i = DW'($urandom_range(15));
        done_i = $urandom_range(1);
        @(posedge clk); @(negedge clk);
      end
    end
    req_valid_i = 1'b0; done_i = 1'b0; rsp_ready_i = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1 || count_o !== '0) begin
      errors++;
      $display("FAIL %s back_idle: valid=%0b busy=%0b ready=%0b count=%0d want 0/0/1/0",
               tag, rsp_valid_o, busy_o, req_ready_o, count_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; req_delay_i = '0; req_id_i = '0;
    done_i = 1'b0; rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (start_o !== 1'b0 || rsp_valid_o !== 1'b0 || rsp_err_o !== 1'b0 || busy_o !== 1'b0 ||
        req_ready_o !== 1'b1 || count_o !== '0 || rsp_id_o !== '0 || rsp_cycles_o !== '0) begin
      errors++;
      $display("FAIL reset_state: start=%0b valid=%0b err=%0b busy=%0b ready=%0b count=%0d id=%0d cyc=%0d",
               start_o, rsp_valid_o, rsp_err_o, busy_o, req_ready_o, count_o, rsp_id_o, rsp_cycles_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    run_op(5, 3, 5, 0, 1'b0, "basic");
  endtask

  task automatic test_zero_delay();
    run_op(0, 6, 1, 0, 1'b0, "zero_delay");
  endtask

  task automatic test_resp_hold();
    run_op(2, 12, 2, 10, 1'b0, "resp_hold");
  endtask

  task automatic test_spurious_done();
    @(negedge clk);
    done_i = 1'b1;
    @(posedge clk); @(negedge clk);
    done_i = 1'b0;
    checks++;
    if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL spur_idle: valid=%0b busy=%0b ready=%0b want 0/0/1", rsp_valid_o, busy_o, req_ready_o);
    end
    run_op(4, 9, 4, 2, 1'b1, "spur_issue");
  endtask

  task automatic test_long_wait();
`ifdef VPU_OP_ISSUER_TIMEOUT_EN
    run_op(7, 1, -1, 0, 1'b0, "timeout");
    run_op(7, 2, TO, 0, 1'b0, "done_at_timeout");
    run_op(7, 4, TO - 1, 0, 1'b0, "done_before_timeout");
`else
    run_op(7, 1, 100, 0, 1'b0, "long_wait");
    run_op(7, 2, 300, 0, 1'b0, "saturate");
`endif
  endtask

  task automatic test_reset_mid_wait();
    @(negedge clk);
    req_valid_i = 1'b1; req_delay_i = 4'd7; req_id_i = 4'd9;
    @(posedge clk); @(negedge clk);
    req_valid_i = 1'b0;
    repeat (4) begin @(posedge clk); @(negedge clk); end
    rst_n = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (busy_o !== 1'b0 || rsp_valid_o !== 1'b0 || start_o !== 1'b0 || rsp_err_o !== 1'b0 ||
        req_ready_o !== 1'b1 || count_o !== '0) begin
      errors++;
      $display("FAIL mid_wait_reset: busy=%0b valid=%0b start=%0b err=%0b ready=%0b count=%0d",
               busy_o, rsp_valid_o, start_o, rsp_err_o, req_ready_o, count_o);
    end
    rst_n = 1'b1;
    done_i = 1'b1;
    @(posedge clk); @(negedge clk);
    done_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_done i=%0d: valid=%0b ready=%0b busy=%0b want 0/1/0",
                 i, rsp_valid_o, req_ready_o, busy_o);
      end
      @(posedge clk); @(negedge clk);
    end
    run_op(3, 5, 3, 0, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(1, 10, 0, 0, 1'b0, "b2b_a");
    run_op(1, 11, 0, 0, 1'b0, "b2b_b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int d, da;
      d  = $urandom_range(15);
      da = ($urandom_range(1) == 1) ? ((d == 0) ? 1 : d) : $urandom_range(20);
      run_op(d, $urandom_range(15), da, $urandom_range(3), $urandom_range(1), "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_delay();
    test_resp_hold();
    test_spurious_done();
    test_long_wait();
    test_reset_mid_wait();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
